// File: rtl/motion_scheduler.sv
// motion_scheduler: splash timer plus regime FSM that turns button or
// accelerometer input into one step command per action tick, with a
// valid/ready handshake toward the object updater.
//
// Ports:
//   pixel_clk, rst_n             clock, async active-low reset
//   end_of_frame                 one-cycle pulse per video frame
//   button_c/u/d/l/r             synchronised level buttons (c = regime select)
//   accel_x, accel_y             two's-complement accelerometer samples
//   step_ready                   updater accepts the pending step
//   step_valid, step_left/right/up/down   registered step command
//   regime                       00 splash, 11 buttons, 10 accel, 01 autopilot
//   logo_active                  high while the splash logo is shown
//
// Optional feature: define MOTION_SCHED_AUTOPILOT_EN to build the autopilot
// regime (right+down for 64 ticks, then left+up for 64 ticks, repeating).
module motion_scheduler #(
  parameter int unsigned FRAMES_PER_ACTION = 2,
  parameter int unsigned LOGO_FRAMES       = 300,
  parameter int unsigned ACCEL_DEADZONE    = 2
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       end_of_frame,
  input  logic       button_c,
  input  logic       button_u,
  input  logic       button_d,
  input  logic       button_l,
  input  logic       button_r,
  input  logic [7:0] accel_x,
  input  logic [7:0] accel_y,
  input  logic       step_ready,
  output logic       step_valid,
  output logic       step_left,
  output logic       step_right,
  output logic       step_up,
  output logic       step_down,
  output logic [1:0] regime,
  output logic       logo_active
);

  localparam int unsigned FRAME_W = 8;
  localparam int unsigned LOGO_W  = 16;
  localparam int unsigned MAG_W   = 9;
  localparam int unsigned DIR_W   = 4;
`ifdef MOTION_SCHED_AUTOPILOT_EN
  localparam int unsigned PHASE_W = 7;
`endif

  // State encoding doubles as the regime output code.
  typedef enum logic [1:0] {
    SPLASH  = 2'b00,
`ifdef MOTION_SCHED_AUTOPILOT_EN
    AUTO    = 2'b01,
`endif
    ACCEL   = 2'b10,
    BUTTONS = 2'b11
  } state_t;

  state_t               state, state_next;
  logic [LOGO_W-1:0]    logo_cnt, logo_cnt_next;
  logic [FRAME_W-1:0]   frame_cnt, frame_cnt_next;
  logic                 btn_c_q;
  logic                 c_rise;
  logic                 tick;
  logic [DIR_W-1:0]     dirs;
  logic [DIR_W-1:0]     dir_q, dir_next;
  logic                 valid_next;
  logic                 logo_next;
  logic [MAG_W-1:0]     mag_x, mag_y;
`ifdef MOTION_SCHED_AUTOPILOT_EN
  logic [PHASE_W-1:0]   phase_cnt, phase_next;
`endif

  // Magnitude of a two's-complement byte; -128 maps to 128, hence 9 bits.
  function automatic logic [MAG_W-1:0] magnitude(input logic [7:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[7], v};
    return v[7] ? (~ext + MAG_W'(1)) : ext;
  endfunction

  assign c_rise = button_c & ~btn_c_q;
  assign mag_x  = magnitude(accel_x);
  assign mag_y  = magnitude(accel_y);

  // Registers.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SPLASH;
      logo_cnt    <= '0;
      frame_cnt   <= '0;
      btn_c_q     <= 1'b0;
      step_valid  <= 1'b0;
      dir_q       <= '0;
      logo_active <= 1'b1;
`ifdef MOTION_SCHED_AUTOPILOT_EN
      phase_cnt   <= '0;
`endif
    end else begin
      state       <= state_next;
      logo_cnt    <= logo_cnt_next;
      frame_cnt   <= frame_cnt_next;
      btn_c_q     <= button_c;
      step_valid  <= valid_next;
      dir_q       <= dir_next;
      logo_active <= logo_next;
`ifdef MOTION_SCHED_AUTOPILOT_EN
      phase_cnt   <= phase_next;
`endif
    end
  end

  // Next-state, counters, direction set and step handshake.
  always_comb begin
    state_next     = state;
    logo_cnt_next  = logo_cnt;
    frame_cnt_next = frame_cnt;
    valid_next     = step_valid;
    dir_next       = dir_q;
    tick           = 1'b0;
    dirs           = '0;
`ifdef MOTION_SCHED_AUTOPILOT_EN
    phase_next     = phase_cnt;
`endif

    case (state)
      SPLASH: begin
        if (end_of_frame) begin
          if (logo_cnt == LOGO_W'(LOGO_FRAMES - 1)) begin
            state_next    = BUTTONS;
            logo_cnt_next = '0;
          end else begin
            logo_cnt_next = logo_cnt + LOGO_W'(1);
          end
        end
      end
      BUTTONS: if (c_rise) state_next = ACCEL;
`ifdef MOTION_SCHED_AUTOPILOT_EN
      ACCEL:   if (c_rise) state_next = AUTO;
      AUTO:    if (c_rise) state_next = BUTTONS;
`else
      ACCEL:   if (c_rise) state_next = BUTTONS;
`endif
      default: state_next = SPLASH;
    endcase

    // Action tick on the wrap of the frame counter; held at 0 during splash.
    if (state == SPLASH) begin
      frame_cnt_next = '0;
    end else if (end_of_frame) begin
      if (frame_cnt == FRAME_W'(FRAMES_PER_ACTION - 1)) begin
        frame_cnt_next = '0;
        tick           = 1'b1;
      end else begin
        frame_cnt_next = frame_cnt + FRAME_W'(1);
      end
    end

    // Direction set {left, right, up, down} from the current (old) regime.
    case (state)
      BUTTONS: dirs = {button_l, button_r & ~button_l, button_u, button_d & ~button_u};
      ACCEL:   dirs = {~accel_y[7] & (mag_y > MAG_W'(ACCEL_DEADZONE)),
                        accel_y[7] & (mag_y > MAG_W'(ACCEL_DEADZONE)),
                        accel_x[7] & (mag_x > MAG_W'(ACCEL_DEADZONE)),
                       ~accel_x[7] & (mag_x > MAG_W'(ACCEL_DEADZONE))};
`ifdef MOTION_SCHED_AUTOPILOT_EN
      AUTO:    dirs = phase_cnt[PHASE_W-1] ? 4'b1010 : 4'b0101;
`endif
      default: dirs = '0;
    endcase

`ifdef MOTION_SCHED_AUTOPILOT_EN
    if (state == AUTO && tick) phase_next = phase_cnt + PHASE_W'(1);
    if (state_next == AUTO && state != AUTO) phase_next = '0;
`endif

    // A tick may issue only when the output slot is free or being accepted.
    if (tick && (!step_valid || step_ready) && (dirs != '0)) begin
      valid_next = 1'b1;
      dir_next   = dirs;
    end else if (step_valid && step_ready) begin
      valid_next = 1'b0;
      dir_next   = '0;
    end

    logo_next = (state_next == SPLASH);
  end

  assign regime     = state;
  assign step_left  = dir_q[3];
  assign step_right = dir_q[2];
  assign step_up    = dir_q[1];
  assign step_down  = dir_q[0];

endmodule

// File: tb/tb_motion_scheduler.sv
// Bench for motion_scheduler: directed stimulus, a cycle-level behavioural
// model of the regime/tick/step rules, a per-cycle compare against it, and
// literal expectations for the key scenarios.
module tb_motion_scheduler;

  localparam int FPA  = 2;
  localparam int LOGO = 3;
  localparam int DZ   = 2;
`ifdef MOTION_SCHED_AUTOPILOT_EN
  localparam bit HAS_AUTO = 1'b1;
`else
  localparam bit HAS_AUTO = 1'b0;
`endif

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic       end_of_frame, button_c, button_u, button_d, button_l, button_r;
  logic [7:0] accel_x, accel_y;
  logic       step_ready;
  logic       step_valid, step_left, step_right, step_up, step_down;
  logic [1:0] regime;
  logic       logo_active;

  motion_scheduler #(
    .FRAMES_PER_ACTION(FPA), .LOGO_FRAMES(LOGO), .ACCEL_DEADZONE(DZ)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .end_of_frame(end_of_frame),
    .button_c(button_c), .button_u(button_u), .button_d(button_d),
    .button_l(button_l), .button_r(button_r),
    .accel_x(accel_x), .accel_y(accel_y), .step_ready(step_ready),
    .step_valid(step_valid), .step_left(step_left), .step_right(step_right),
    .step_up(step_up), .step_down(step_down),
    .regime(regime), .logo_active(logo_active)
  );

  always #5 pixel_clk = ~pixel_clk;

  int passed = 0;
  int total  = 0;
  bit started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 splash, 1 buttons, 2 accel, 3 autopilot
  int         m_mode = 0, m_logo = 0, m_frames = 0, m_auto = 0;
  bit         m_prev_c = 1'b0, m_valid = 1'b0;
  logic [3:0] m_dir = 4'b0;          // {left, right, up, down}
  bit         m_tick;
  int         m_nm;
  logic [3:0] m_want;

  function automatic logic [1:0] enc(input int mode);
    case (mode)
      1: return 2'b11;
      2: return 2'b10;
      3: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] want_dirs(input int mode, input int auto_ticks);
    int ax, ay, mx, my;
    ax = int'($signed(accel_x));
    ay = int'($signed(accel_y));
    mx = (ax < 0) ? -ax : ax;
    my = (ay < 0) ? -ay : ay;
    case (mode)
      1: return {button_l, button_r && !button_l, button_u, button_d && !button_u};
      2: return {ay >= 0 && my > DZ, ay < 0 && my > DZ, ax < 0 && mx > DZ, ax >= 0 && mx > DZ};
      3: return ((auto_ticks / 64) % 2 == 0) ? 4'b0101 : 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  initial forever begin
    @(posedge pixel_clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_logo = 0; m_frames = 0; m_auto = 0;
      m_prev_c = 1'b0; m_valid = 1'b0; m_dir = 4'b0;
    end else begin
      m_tick = 1'b0;
      if (m_mode != 0 && end_of_frame) begin
        m_frames++;
        m_tick = (m_frames % FPA == 0);
      end
      m_want = m_tick ? want_dirs(m_mode, m_auto) : 4'b0;
      if (m_tick && m_mode == 3) m_auto++;
      if (m_tick && (!m_valid || step_ready) && m_want != 4'b0) begin
        m_valid = 1'b1; m_dir = m_want;
      end else if (m_valid && step_ready) begin
        m_valid = 1'b0; m_dir = 4'b0;
      end
      m_nm = m_mode;
      if (m_mode == 0) begin
        if (end_of_frame) begin
          m_logo++;
          if (m_logo == LOGO) m_nm = 1;
        end
      end else if (button_c && !m_prev_c) begin
        if (m_mode == 1) m_nm = 2;
        else if (m_mode == 2) m_nm = HAS_AUTO ? 3 : 1;
        else m_nm = 1;
      end
      if (m_nm == 3 && m_mode != 3) m_auto = 0;
      m_mode   = m_nm;
      m_prev_c = button_c;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge pixel_clk);
    #2;
    if (started) begin
      total++;
      if (step_valid === m_valid &&
          {step_left, step_right, step_up, step_down} === m_dir &&
          regime === enc(m_mode) && logo_active === (m_mode == 0))
        passed++;
      else
        $display("FAIL cycle t=%0t: valid/dir/regime/logo got %b/%b/%b/%b, expected %b/%b/%b/%b",
                 $time, step_valid, {step_left, step_right, step_up, step_down}, regime,
                 logo_active, m_valid, m_dir, enc(m_mode), (m_mode == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic       after_v, next_v;
  logic [3:0] after_d;
  logic [1:0] after_reg;

  task automatic idle(input int n);
    repeat (n) @(posedge pixel_clk);
    #5;
  endtask

  // One end_of_frame pulse; optionally raise button_c / step_ready with it.
  // Records outputs right after the sampling edge and one cycle later.
  task automatic frame_pulse(input bit c_rise = 1'b0, input bit rdy_set = 1'b0);
    @(posedge pixel_clk);
    #5;
    end_of_frame = 1'b1;
    if (c_rise)  button_c   = 1'b1;
    if (rdy_set) step_ready = 1'b1;
    @(posedge pixel_clk);
    #2;
    after_v   = step_valid;
    after_d   = {step_left, step_right, step_up, step_down};
    after_reg = regime;
    #3;
    end_of_frame = 1'b0;
    @(posedge pixel_clk);
    #2;
    next_v = step_valid;
    #3;
    idle(2);
  endtask

  task automatic pair();
    frame_pulse();
    frame_pulse();
  endtask

  initial begin
    end_of_frame = 0; button_c = 0; button_u = 0; button_d = 0;
    button_l = 0; button_r = 0; accel_x = 8'h00; accel_y = 8'h00; step_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    started = 1'b1;
    #1;
    check("reset_logo_active", int'(logo_active), 1);
    check("reset_step_valid", int'(step_valid), 0);
    check("reset_regime", int'(regime), 0);
    idle(3);
    rst_n = 1'b1;

    // Splash: button_c ignored, exit after the third pulse.
    button_c = 1'b1; idle(2); button_c = 1'b0; idle(1);
    check("splash_ignores_c", int'(regime), 0);
    frame_pulse(); frame_pulse();
    check("splash_pulse2_regime", int'(after_reg), 0);
    check("splash_pulse2_logo", int'(logo_active), 1);
    frame_pulse();
    check("splash_exit_regime", int'(after_reg), 3);
    check("splash_exit_logo", int'(logo_active), 0);

    // Buttons: left wins over right, one-cycle step every 2nd frame.
    button_l = 1; button_r = 1; step_ready = 1; idle(1);
    frame_pulse();
    check("btn_odd_frame_no_step", int'(after_v), 0);
    frame_pulse();
    check("btn_tick_valid", int'(after_v), 1);
    check("btn_tick_dir_left", int'(after_d), 4'b1000);
    check("btn_valid_one_cycle", int'(next_v), 0);
    button_l = 0; button_u = 1; button_d = 1;
    pair();
    check("btn_right_up", int'(after_d), 4'b0110);

    // Backpressure: step held stable, later ticks dropped.
    button_u = 0; button_d = 0; button_r = 0; button_l = 1; step_ready = 0;
    pair();
    check("bp_issue_dir", int'(after_d), 4'b1000);
    button_l = 0; button_r = 1;
    pair(); pair();
    check("bp_held_valid", int'(step_valid), 1);
    check("bp_held_dir", int'({step_left, step_right, step_up, step_down}), 4'b1000);
    step_ready = 1;
    #1;
    check("bp_handshake_cycle_valid", int'(step_valid), 1);
    @(posedge pixel_clk);
    #2;
    check("bp_valid_falls", int'(step_valid), 0);
    #3;

    // Tick in the same cycle as an accept reissues a new step.
    step_ready = 0; button_r = 0; button_l = 1;
    pair();
    button_l = 0; button_u = 1;
    frame_pulse();
    frame_pulse(1'b0, 1'b1);
    check("hs_tick_reissue_valid", int'(after_v), 1);
    check("hs_tick_reissue_dir", int'(after_d), 4'b0010);
    check("hs_reissue_accepted", int'(next_v), 0);

    // button_c held 10 frames with a pending step: one regime change only.
    step_ready = 0; button_u = 0; button_l = 1;
    pair();
    button_c = 1;
    repeat (10) frame_pulse();
    check("c_held_regime_accel", int'(regime), 2);
    check("c_pending_kept", int'({step_valid, step_left, step_right, step_up, step_down}), 5'b11000);
    button_c = 0; button_l = 0; step_ready = 1; idle(2);
    check("c_pending_completed", int'(step_valid), 0);

    // Accelerometer regime.
    accel_y = 8'hF0; accel_x = 8'h01;
    pair();
    check("acc_right_only", int'(after_d), 4'b0100);
    accel_x = 8'h05;
    pair();
    check("acc_right_down", int'(after_d), 4'b0101);
    accel_y = 8'h80; accel_x = 8'h80;
    pair();
    check("acc_min_neg", int'(after_d), 4'b0110);
    accel_y = 8'h02; accel_x = 8'hFE;
    pair();
    check("acc_deadzone_no_step", int'(after_v), 0);
    accel_y = 8'h03; accel_x = 8'h03;
    pair();
    check("acc_left_down", int'(after_d), 4'b1001);

    // button_c edge on a tick: tick uses the old (accel) regime.
    accel_y = 8'hF0; accel_x = 8'h00;
    frame_pulse();
    frame_pulse(1'b1, 1'b0);
    check("c_tick_old_regime_dir", int'(after_d), 4'b0100);
    check("c_tick_new_regime", int'(after_reg), HAS_AUTO ? 1 : 3);
    button_c = 0; idle(1);

`ifdef MOTION_SCHED_AUTOPILOT_EN
    for (int k = 1; k <= 130; k++) begin
      pair();
      check("auto_tick_dir", int'(after_d), (k <= 64 || k == 129 || k == 130) ? 4'b0101 : 4'b1010);
    end
    button_c = 1; idle(2); button_c = 0; idle(1);
    check("auto_to_buttons", int'(regime), 3);
`else
    button_c = 1; idle(2); button_c = 0; idle(1);
    check("cycle_to_accel", int'(regime), 2);
    button_c = 1; idle(2); button_c = 0; idle(1);
    check("accel_back_to_buttons", int'(regime), 3);
`endif

    // Reset asserted mid-handshake clears everything asynchronously.
    step_ready = 0; button_l = 1;
    pair();
    check("pre_reset_pending", int'(step_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(step_valid), 0);
    check("async_reset_dir", int'({step_left, step_right, step_up, step_down}), 0);
    check("async_reset_regime", int'(regime), 0);
    check("async_reset_logo", int'(logo_active), 1);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
